// File: rtl/norm_pkg.sv
// Shared types and default widths for the norm packer, plus the lowest-set-lane selector.
package norm_pkg;
  localparam int LANES           = 8;
  localparam int NORM_W          = 32;
  localparam int SCALE_W         = 6;
  localparam int DEF_IDX_W       = 32;
  localparam int DEF_GROUP_DEPTH = 4;
  localparam int LANE_W          = $clog2(LANES);

  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic [NORM_W-1:0]    norm;
    logic [SCALE_W-1:0]   scale;
    logic                 last;
  } norm_entry_t;

  typedef struct packed {
    logic [LANES-1:0]              mask;
    logic [LANES-1:0][NORM_W-1:0]  norm;
    logic [LANES-1:0][SCALE_W-1:0] scale;
  } norm_group_t;

  function automatic logic [LANE_W-1:0] lsb_index(input logic [LANES-1:0] m);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) r = LANE_W'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/norm_group_fifo.sv
// Synchronous group FIFO; exposes head and the entry behind it so the drainer can
// chain groups without a bubble. Push while full is accepted when a pop happens too.
module norm_group_fifo
  import norm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     push,
  input  norm_group_t              push_dat,
  input  logic                     pop,
  output norm_group_t              head,
  output norm_group_t              next_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  norm_group_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q, rd_nxt;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_nxt   = rd_q + 1'b1;
  assign head     = mem_q[rd_q];
  assign next_dat = mem_q[rd_nxt];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/norm_packer.sv
// Buffers sparse per-lane inverse-norm groups and serializes set lanes into an indexed
// ready/valid stream. Define NORM_PACKER_STATS_EN for saturating accepted/dropped counters.
module norm_packer
  import norm_pkg::*;
#(
  parameter int IDX_W       = DEF_IDX_W,
  parameter int GROUP_DEPTH = DEF_GROUP_DEPTH
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic [LANES-1:0]         in_mask,
  input  logic [LANES*NORM_W-1:0]  in_norm,
  input  logic [LANES*SCALE_W-1:0] in_scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [NORM_W-1:0]        out_norm,
  output logic [SCALE_W-1:0]       out_scale,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overflow
`ifdef NORM_PACKER_STATS_EN
  ,
  output logic [31:0]              stat_groups,
  output logic [31:0]              stat_dropped
`endif
);
  localparam int CW = $clog2(GROUP_DEPTH) + 1;

  norm_group_t        grp_in, fifo_head, fifo_next;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_cnt;
  logic [LANES-1:0]   wmask_q, wmask_d, rem_mask, next_mask;
  logic [LANE_W-1:0]  sel;
  logic               ld, is_last, pop, push, drop;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic               overflow_q, overflow_d;
  logic [IDX_W-1:0]   idx_cnt_q, idx_cnt_d, out_idx_q, out_idx_d;
  logic [NORM_W-1:0]  out_norm_q, out_norm_d;
  logic [SCALE_W-1:0] out_scale_q, out_scale_d;

  assign grp_in = {in_mask, in_norm, in_scale};

  norm_group_fifo #(.DEPTH(GROUP_DEPTH)) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (clear),
    .push     (push),
    .push_dat (grp_in),
    .pop      (pop),
    .head     (fifo_head),
    .next_dat (fifo_next),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    sel       = lsb_index(wmask_q);
    rem_mask  = wmask_q & (wmask_q - 1'b1);
    is_last   = (rem_mask == '0);
    ld        = (wmask_q != '0) && (!out_valid_q || out_ready);
    pop       = ld && is_last;
    push      = !clear && (in_mask != '0) && (!fifo_full || pop);
    drop      = !clear && (in_mask != '0) && !push;
    // On the final lane the working mask reloads straight from the following group.
    next_mask = (fifo_cnt > CW'(1)) ? fifo_next.mask : (push ? in_mask : '0);

    wmask_d     = wmask_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_norm_d  = out_norm_q;
    out_scale_d = out_scale_q;
    out_last_d  = out_last_q;
    idx_cnt_d   = idx_cnt_q;
    overflow_d  = overflow_q;

    if (clear) begin
      wmask_d     = '0;
      out_valid_d = 1'b0;
      out_idx_d   = '0;
      out_norm_d  = '0;
      out_scale_d = '0;
      out_last_d  = 1'b0;
      idx_cnt_d   = '0;
      overflow_d  = 1'b0;
    end else begin
      if (ld) begin
        out_valid_d = 1'b1;
        out_idx_d   = idx_cnt_q;
        out_norm_d  = fifo_head.norm[sel];
        out_scale_d = fifo_head.scale[sel];
        out_last_d  = is_last;
        idx_cnt_d   = idx_cnt_q + 1'b1;
        wmask_d     = is_last ? next_mask : rem_mask;
      end else begin
        if (out_ready) out_valid_d = 1'b0;
        if (wmask_q == '0 && !fifo_empty) wmask_d = fifo_head.mask;
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wmask_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_norm_q  <= '0;
      out_scale_q <= '0;
      out_last_q  <= 1'b0;
      idx_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wmask_q     <= wmask_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_norm_q  <= out_norm_d;
      out_scale_q <= out_scale_d;
      out_last_q  <= out_last_d;
      idx_cnt_q   <= idx_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_norm  = out_norm_q;
  assign out_scale = out_scale_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign busy      = !fifo_empty || out_valid_q;

`ifdef NORM_PACKER_STATS_EN
  logic [31:0] stat_groups_q, stat_dropped_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_groups_q  <= '0;
      stat_dropped_q <= '0;
    end else if (clear) begin
      stat_groups_q  <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (push && stat_groups_q != '1)  stat_groups_q  <= stat_groups_q + 1'b1;
      if (drop && stat_dropped_q != '1) stat_dropped_q <= stat_dropped_q + 1'b1;
    end
  end

  assign stat_groups  = stat_groups_q;
  assign stat_dropped = stat_dropped_q;
`endif
endmodule

// File: tb/tb_norm_packer.sv
// Scoreboard bench: two packers (32-bit and 4-bit index) share stimulus; monitors pop expectations.
module tb_norm_packer;
  import norm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     nrst, clear, out_ready;
  logic [LANES-1:0]         in_mask;
  logic [LANES*NORM_W-1:0]  in_norm;
  logic [LANES*SCALE_W-1:0] in_scale;

  logic               a_valid, a_last, a_busy, a_ovf;
  logic [31:0]        a_idx;
  logic [NORM_W-1:0]  a_norm;
  logic [SCALE_W-1:0] a_scale;
  logic               b_valid, b_last, b_busy, b_ovf;
  logic [3:0]         b_idx;
  logic [NORM_W-1:0]  b_norm;
  logic [SCALE_W-1:0] b_scale;
`ifdef NORM_PACKER_STATS_EN
  logic [31:0] a_sg, a_sd, b_sg, b_sd;
`endif

  norm_packer dut (
    .clk(clk), .nrst(nrst), .clear(clear), .in_mask(in_mask), .in_norm(in_norm),
    .in_scale(in_scale), .out_valid(a_valid), .out_ready(out_ready), .out_idx(a_idx),
    .out_norm(a_norm), .out_scale(a_scale), .out_last(a_last), .busy(a_busy),
    .overflow(a_ovf)
`ifdef NORM_PACKER_STATS_EN
    , .stat_groups(a_sg), .stat_dropped(a_sd)
`endif
  );

  norm_packer #(.IDX_W(4)) dut_w (
    .clk(clk), .nrst(nrst), .clear(clear), .in_mask(in_mask), .in_norm(in_norm),
    .in_scale(in_scale), .out_valid(b_valid), .out_ready(out_ready), .out_idx(b_idx),
    .out_norm(b_norm), .out_scale(b_scale), .out_last(b_last), .busy(b_busy),
    .overflow(b_ovf)
`ifdef NORM_PACKER_STATS_EN
    , .stat_groups(b_sg), .stat_dropped(b_sd)
`endif
  );

  typedef struct packed {
    logic [31:0]        idx;
    logic [NORM_W-1:0]  norm;
    logic [SCALE_W-1:0] scale;
    logic               last;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          checks = 0;
  int          errors = 0;
  int          seen = 0;
  logic [31:0] exp_idx = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst && a_valid && out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got idx %0h with empty scoreboard", a_idx);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_entry", {a_idx, a_norm, a_scale, a_last}, e);
        seen++;
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && b_valid && out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got idx %0h with empty scoreboard", b_idx);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_entry_wrap", {b_idx, b_norm, b_scale, b_last},
              {e.idx[3:0], e.norm, e.scale, e.last});
      end
    end
  end

  // One-cycle group pulse; expected entries are queued only when the group should be accepted.
  task automatic send(input logic [7:0] mask, input logic [31:0] nbase, input bit accept);
    exp_t e;
    in_mask = mask;
    for (int l = 0; l < LANES; l++) begin
      in_norm[l*NORM_W +: NORM_W]    = nbase + 32'(l);
      in_scale[l*SCALE_W +: SCALE_W] = SCALE_W'(l + 3);
    end
    if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (mask[l]) begin
          e.idx   = exp_idx;
          e.norm  = nbase + 32'(l);
          e.scale = SCALE_W'(l + 3);
          e.last  = ((mask >> (l + 1)) == 8'h00);
          qa.push_back(e);
          qb.push_back(e);
          exp_idx = exp_idx + 1;
        end
      end
    end
    @(posedge clk); #1;
    in_mask = '0;
  endtask

  task automatic flush_model();
    qa.delete();
    qb.delete();
    exp_idx = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_model();
  endtask

  task automatic wait_seen(input int target);
    int n = 0;
    while (seen < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_seen", seen, target);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((qa.size() != 0 || a_busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {qa.size(), a_busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int run;
    int base;
    nrst = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_mask = '0; in_norm = '0; in_scale = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_last", {a_valid, a_last, b_valid}, 0);
    check("rst_idx_norm_scale", {a_idx, a_norm, a_scale}, 0);
    check("rst_busy_ovf", {a_busy, a_ovf, b_busy, b_ovf}, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Full group: latency and eight back-to-back entries.
    send(8'hFF, 32'h100, 1'b1);
    @(posedge clk); #1;
    check("lat_n1_valid", a_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_n2_valid", a_valid, 1'b1);
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_valid) run++;
      @(posedge clk); #1;
    end
    check("full_consecutive", run, 8);
    check("full_done_idle", {a_valid, a_busy}, 0);

    // Sparse group restarts at index 0 after clear.
    do_clear();
    send(8'b0010_0101, 32'h200, 1'b1);
    wait_drain("sparse_drain");

    // Clear after three entries of a full group.
    base = seen;
    send(8'hFF, 32'h300, 1'b1);
    wait_seen(base + 3);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    flush_model();
    check("clear_valid_busy", {a_valid, a_busy, b_valid, b_busy}, 0);
    send(8'h0F, 32'h400, 1'b1);
    wait_drain("post_clear_drain");

    // Backpressure mid-group: presented entry must hold for five cycles.
    base = seen;
    send(8'hFF, 32'h500, 1'b1);
    wait_seen(base + 3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_hold", {a_valid, a_idx, a_norm, a_scale, a_last}, {1'b1, qa[0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("stall_drain");

    // Overflow: four groups fill the FIFO while stalled, the fifth is dropped.
    do_clear();
    check("ovf_clear", a_ovf, 1'b0);
    out_ready = 1'b0;
    send(8'hFF, 32'h600, 1'b1);
    send(8'hFF, 32'h610, 1'b1);
    send(8'hFF, 32'h620, 1'b1);
    send(8'hFF, 32'h630, 1'b1);
    check("ovf_before_drop", {a_ovf, b_ovf}, 0);
    send(8'hFF, 32'h640, 1'b0);
    check("ovf_after_drop", {a_ovf, b_ovf}, 2'b11);
`ifdef NORM_PACKER_STATS_EN
    check("stat_groups", a_sg, 4);
    check("stat_dropped", a_sd, 1);
`endif
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 32; i++) begin
      if (a_valid) run++;
      @(posedge clk); #1;
    end
    check("ovf_drain_consecutive", run, 32);
    check("ovf_drain_idle", {a_valid, a_busy}, 0);
    check("ovf_sticky", a_ovf, 1'b1);
    do_clear();
    check("ovf_cleared", {a_ovf, b_ovf}, 0);
`ifdef NORM_PACKER_STATS_EN
    check("stats_cleared", {a_sg, a_sd}, 0);
`endif

    // Three back-to-back groups: no bubble at group boundaries, narrow index wraps.
    send(8'hFF, 32'h700, 1'b1);
    send(8'hFF, 32'h710, 1'b1);
    send(8'hFF, 32'h720, 1'b1);
    run = 0;
    for (int i = 0; i < 24; i++) begin
      if (a_valid && b_valid) run++;
      @(posedge clk); #1;
    end
    check("wrap_no_bubble", run, 24);
    wait_drain("wrap_drain");
    check("final_queues_empty", {qa.size(), qb.size()}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
